// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a small FIFO of
// {pc, instruction} pairs toward the decoder, with redirect flush handling.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned   PW        = $clog2(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_IDX  = PW'(BUF_DEPTH - 1);
    localparam logic [3:0]    DEPTH_C   = 4'(BUF_DEPTH);
    localparam logic [31:0]   RESET_FPC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state, state_next;
    logic [31:0]   fpc, fpc_next;
    logic [31:0]   drop_addr, drop_addr_next;
    logic [3:0]    count, count_next;
    logic [PW-1:0] head, tail;
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [31:0]   buf_data [BUF_DEPTH];
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : PW'(p + 1'b1);
    endfunction

    assign push       = (state == REQ) && imem_ack && !redirect_valid;
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst_valid = (count != '0);
    assign imem_req   = (state != IDLE);
    // DROP keeps presenting the abandoned address while fpc already holds the redirect target
    assign imem_addr  = (state == DROP) ? drop_addr : fpc;
    assign inst_pc    = buf_pc[head];
    assign inst_data  = buf_data[head];

    always_comb begin
        state_next     = state;
        fpc_next       = fpc;
        drop_addr_next = drop_addr;
        count_next     = count + 4'(push) - 4'(pop);
        if (redirect_valid) begin
            count_next = '0;
            fpc_next   = {redirect_pc[31:2], 2'b00};
        end
        case (state)
            IDLE: begin
                if (redirect_valid || (count_next < DEPTH_C)) state_next = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    if (!imem_ack) begin
                        state_next     = DROP;
                        drop_addr_next = fpc;
                    end
                end else if (imem_ack) begin
                    fpc_next   = fpc + 32'd4;
                    state_next = (count_next < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fpc       <= RESET_FPC;
            drop_addr <= RESET_FPC;
            count     <= '0;
        end else begin
            state     <= state_next;
            fpc       <= fpc_next;
            drop_addr <= drop_addr_next;
            count     <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                buf_pc[tail]   <= fpc;
                buf_data[tail] <= imem_rdata;
                tail           <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic checked
// against an in-order program-counter stream model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_data, w_pc;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_acks   = 0;
    int unsigned n_consumed = 0;
    logic [31:0] exp_pc = '0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        after_redir = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    ifetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    // Second instance: wrap-around start address, memory always ready, decoder always ready
    assign w_rdata = mem_word(w_addr);
    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_req), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_valid), .inst_data(w_data), .inst_pc(w_pc),
        .inst_ready(1'b1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called just after a falling edge: check outputs, drive inputs for the next rising edge.
    task automatic step(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
        if (prev_wait) begin
            check_eq("req_hold", 32'(imem_req), 32'd1);
            check_eq("addr_hold", imem_addr, prev_addr);
        end
        if (after_redir) check_eq("flush_valid", 32'(inst_valid), 32'd0);
        check_eq("addr_align", 32'(imem_addr[1:0]), 32'd0);
        imem_ack       = ack && imem_req;
        imem_rdata     = imem_ack ? mem_word(imem_addr) : $urandom;
        inst_ready     = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (imem_ack) n_acks++;
        if (inst_valid && ready && !redir) begin
            check_eq("stream_pc", inst_pc, exp_pc);
            check_eq("stream_data", inst_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end
        if (redir) exp_pc = {rpc[31:2], 2'b00};
        prev_wait   = imem_req && !imem_ack;
        prev_addr   = imem_addr;
        after_redir = redir;
        @(negedge clk);
    endtask

    // Entered just after a falling edge; asserts reset mid-cycle and checks outputs at once.
    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_pc", inst_pc, 32'h0);
        check_eq("rst_data", inst_data, 32'h0);
        check_eq("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        exp_pc      = '0;
        prev_wait   = 1'b0;
        after_redir = 1'b0;
        @(negedge clk);
        check_eq("post_rst_req", 32'(imem_req), 32'd1);
        check_eq("post_rst_addr", imem_addr, 32'h0);
        n_acks = 0;
    endtask

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);

        // Streaming: one instruction per cycle; wrap instance crosses 0xFFFFFFFC -> 0
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) check_eq("wrap_first_addr", w_addr, 32'hFFFF_FFF8);
            if (k >= 1 && k <= 3) begin
                check_eq("wrap_pc", w_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
                check_eq("wrap_data", w_data, mem_word(32'hFFFF_FFF8 + 32'(4 * (k - 1))));
            end
            if (k >= 1) check_eq("stream_valid", 32'(inst_valid), 32'd1);
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end

        // Decoder stalled: buffer fills after two fetches, then resumes at 8
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("full_acks", n_acks, 32'd2);
        check_eq("full_req", 32'(imem_req), 32'd0);
        check_eq("full_head_pc", inst_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("resume_req", 32'(imem_req), 32'd1);
        check_eq("resume_addr", imem_addr, 32'h8);

        // Delayed ack: request held, inst_valid one cycle after ack
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check_eq("wait_req", 32'(imem_req), 32'd1);
            check_eq("wait_addr", imem_addr, 32'h0);
            check_eq("wait_valid", 32'(inst_valid), 32'd0);
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("late_valid", 32'(inst_valid), 32'd1);
        check_eq("late_data", inst_data, mem_word(32'h0));

        // Redirect while request to 8 is pending
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("pend_addr", imem_addr, 32'h8);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        check_eq("drop_req", 32'(imem_req), 32'd1);
        check_eq("drop_addr", imem_addr, 32'h8);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("redir_req", 32'(imem_req), 32'd1);
        check_eq("redir_addr", imem_addr, 32'h100);
        check_eq("redir_nodata", 32'(inst_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("redir_pc", inst_pc, 32'h100);

        // Randomized traffic against the stream model
        n_consumed = 0;
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 3, $urandom);
        end
        check_eq("rand_progress", 32'(n_consumed > 300), 32'd1);

        // Reset in the middle of an outstanding request
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("mid_pending", 32'(imem_req), 32'd1);
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("restart_next", exp_pc, 32'h10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
